// File: rtl/ghost_pkg.sv
// Shared types and the level-1 phase schedule for the ghost mode controller.
package ghost_pkg;

    // Ghost heading encoding used by the movement blocks downstream.
    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_e;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_START_WAIT = 2'd1,
        ST_RUN        = 2'd2
    } state_e;

    localparam int          TMR_W      = 16;
    localparam logic [2:0]  LAST_PHASE = 3'd7;

    // Duration of a schedule phase: scatter A for 0/2, scatter B for 4/6,
    // chase for the odd phases (phase 7 never counts down).
    function automatic logic [TMR_W-1:0] phase_ms(input logic [2:0]       ph,
                                                  input logic [TMR_W-1:0] scat_a,
                                                  input logic [TMR_W-1:0] scat_b,
                                                  input logic [TMR_W-1:0] chase);
        case (ph)
            3'd0, 3'd2: return scat_a;
            3'd4, 3'd6: return scat_b;
            default:    return chase;
        endcase
    endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Prescaler producing a one-cycle tick every CLK_HZ/TICK_HZ enabled cycles.
module ms_tick_gen #(
    parameter int CLK_HZ  = 25_000_000,
    parameter int TICK_HZ = 1000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    output logic tick
);

    localparam int             DIV  = CLK_HZ / TICK_HZ;
    localparam int             CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0]  LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;

    // Free-running 0..DIV-1 counter that holds while disabled.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
        end
    end

    // With DIV=1 the counter sits at 0 == LAST, so every enabled cycle ticks.
    assign tick = en && (cnt_q == LAST);

endmodule

// File: rtl/ghost_mode_ctrl.sv
// Global scatter/chase scheduler for all ghosts.
// Optional frightened mode is compiled in with `define FRIGHTENED_EN.
module ghost_mode_ctrl #(
    parameter int CLK_HZ         = 25_000_000,
    parameter int TICK_HZ        = 1000,
    parameter int START_DELAY_MS = 5000,
    parameter int SCATTER_A_MS   = 7000,
    parameter int SCATTER_B_MS   = 5000,
    parameter int CHASE_MS       = 20000,
    parameter int FRIGHT_MS      = 6000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       game_start,
    input  logic       pause,
    input  logic       life_lost,
    input  logic       energizer_eaten,
    output logic       isChase,
    output logic       isScatter,
    output logic       isFrightened,
    output logic       reverse_pulse,
    output logic [2:0] phase
);
    import ghost_pkg::*;

    localparam logic [TMR_W-1:0] START_T  = TMR_W'(START_DELAY_MS);
    localparam logic [TMR_W-1:0] SCAT_A_T = TMR_W'(SCATTER_A_MS);
    localparam logic [TMR_W-1:0] SCAT_B_T = TMR_W'(SCATTER_B_MS);
    localparam logic [TMR_W-1:0] CHASE_T  = TMR_W'(CHASE_MS);

    state_e           state_q;
    logic [2:0]       phase_q;
    logic [TMR_W-1:0] tmr_q;
    logic             chase_q, scatter_q, rev_q;
    logic             tick;
    logic [2:0]       ph_nxt;

    assign ph_nxt = phase_q + 3'd1;

    // Pause stops the prescaler, which in turn freezes every timer.
    ms_tick_gen #(
        .CLK_HZ  (CLK_HZ),
        .TICK_HZ (TICK_HZ)
    ) u_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (!pause),
        .tick    (tick)
    );

`ifdef FRIGHTENED_EN
    localparam logic [TMR_W-1:0] FRIGHT_T = TMR_W'(FRIGHT_MS);
    logic             fright_q;
    logic [TMR_W-1:0] fr_tmr_q;
    assign isFrightened = fright_q;
`else
    logic [TMR_W:0] unused_cfg;
    assign unused_cfg   = {energizer_eaten, TMR_W'(FRIGHT_MS)};
    assign isFrightened = 1'b0;
`endif

    // Mode FSM: start delay, phase schedule, life-loss restart, fright overlay.
    always_ff @(posedge clk) begin
        rev_q <= 1'b0;
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            phase_q   <= 3'd0;
            tmr_q     <= '0;
            chase_q   <= 1'b0;
            scatter_q <= 1'b0;
`ifdef FRIGHTENED_EN
            fright_q  <= 1'b0;
            fr_tmr_q  <= '0;
`endif
        end else if (life_lost && state_q != ST_IDLE) begin
            state_q   <= ST_START_WAIT;
            phase_q   <= 3'd0;
            tmr_q     <= START_T;
            chase_q   <= 1'b0;
            scatter_q <= 1'b0;
`ifdef FRIGHTENED_EN
            fright_q  <= 1'b0;
            fr_tmr_q  <= '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (game_start) begin
                        state_q <= ST_START_WAIT;
                        tmr_q   <= START_T;
                    end
                end
                ST_START_WAIT: begin
                    if (tick) begin
                        if (tmr_q == TMR_W'(1)) begin
                            state_q   <= ST_RUN;
                            phase_q   <= 3'd0;
                            tmr_q     <= phase_ms(3'd0, SCAT_A_T, SCAT_B_T, CHASE_T);
                            scatter_q <= 1'b1;
                        end else begin
                            tmr_q <= tmr_q - TMR_W'(1);
                        end
                    end
                end
                ST_RUN: begin
`ifdef FRIGHTENED_EN
                    // Eating wins over any expiry this cycle; only the first
                    // entry into fright turns the ghosts around.
                    if (energizer_eaten) begin
                        fr_tmr_q  <= FRIGHT_T;
                        fright_q  <= 1'b1;
                        chase_q   <= 1'b0;
                        scatter_q <= 1'b0;
                        if (!fright_q) rev_q <= 1'b1;
                    end else if (fright_q) begin
                        if (tick) begin
                            if (fr_tmr_q == TMR_W'(1)) begin
                                fright_q  <= 1'b0;
                                chase_q   <= phase_q[0];
                                scatter_q <= ~phase_q[0];
                            end else begin
                                fr_tmr_q <= fr_tmr_q - TMR_W'(1);
                            end
                        end
                    end else
`endif
                    if (tick && phase_q != LAST_PHASE) begin
                        if (tmr_q == TMR_W'(1)) begin
                            phase_q   <= ph_nxt;
                            tmr_q     <= phase_ms(ph_nxt, SCAT_A_T, SCAT_B_T, CHASE_T);
                            chase_q   <= ph_nxt[0];
                            scatter_q <= ~ph_nxt[0];
                            rev_q     <= 1'b1;
                        end else begin
                            tmr_q <= tmr_q - TMR_W'(1);
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign isChase       = chase_q;
    assign isScatter     = scatter_q;
    assign reverse_pulse = rev_q;
    assign phase         = phase_q;

endmodule

// File: tb/tb_ghost_mode_ctrl.sv
// Bench for ghost_mode_ctrl: directed scenarios on a 1-tick-per-cycle instance
// plus randomized traffic on that and a 3-cycles-per-tick instance.
module tb_ghost_mode_ctrl;

    localparam int SD = 3;
    localparam int SA = 7;
    localparam int SB = 5;
    localparam int CH = 20;

    logic clk = 1'b0;
    logic reset_n = 1'b0, game_start = 1'b0, pause = 1'b0;
    logic life_lost = 1'b0, energizer_eaten = 1'b0;
    logic [1:0]      ch, sc, fr, rv;
    logic [1:0][2:0] ph;

    int n_cmp = 0;
    int n_err = 0;

    // reference state: ticks since (re)start, enabled cycles since reset
    bit st   [2];
    int nt   [2];
    int g    [2];
    bit erev [2];

    always #5 clk = ~clk;

    ghost_mode_ctrl #(.CLK_HZ(1000), .TICK_HZ(1000), .START_DELAY_MS(SD),
        .SCATTER_A_MS(SA), .SCATTER_B_MS(SB), .CHASE_MS(CH), .FRIGHT_MS(6)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .game_start(game_start), .pause(pause),
        .life_lost(life_lost), .energizer_eaten(energizer_eaten),
        .isChase(ch[0]), .isScatter(sc[0]), .isFrightened(fr[0]),
        .reverse_pulse(rv[0]), .phase(ph[0]));

    ghost_mode_ctrl #(.CLK_HZ(3000), .TICK_HZ(1000), .START_DELAY_MS(SD),
        .SCATTER_A_MS(SA), .SCATTER_B_MS(SB), .CHASE_MS(CH), .FRIGHT_MS(6)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .game_start(game_start), .pause(pause),
        .life_lost(life_lost), .energizer_eaten(energizer_eaten),
        .isChase(ch[1]), .isScatter(sc[1]), .isFrightened(fr[1]),
        .reverse_pulse(rv[1]), .phase(ph[1]));

    function automatic int div_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic int dur(input int p);
        case (p)
            0, 2:    return SA;
            4, 6:    return SB;
            default: return CH;
        endcase
    endfunction

    // phase reached after nn ticks since start, -1 while still in the start delay
    function automatic int phase_of(input int nn);
        int s, p;
        if (nn < SD) return -1;
        s = nn - SD;
        p = 0;
        while (p < 7 && s >= dur(p)) begin
            s -= dur(p);
            p++;
        end
        return p;
    endfunction

    // {isChase, isScatter, isFrightened, reverse_pulse, phase}
    function automatic logic [6:0] exp_vec(input int i);
        int p;
        logic [6:0] v;
        v = '0;
        if (st[i]) begin
            p = phase_of(nt[i]);
            if (p >= 0) begin
                v[6]   = p[0];
                v[5]   = ~p[0];
                v[2:0] = p[2:0];
            end
        end
        v[3] = erev[i];
        return v;
    endfunction

    function automatic logic [6:0] obs(input int i);
        return {ch[i], sc[i], fr[i], rv[i], ph[i]};
    endfunction

    task automatic step(input bit rst, input bit gs, input bit ps, input bit ll, input bit ee);
        reset_n = !rst; game_start = gs; pause = ps; life_lost = ll; energizer_eaten = ee;
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            bit tk;
            int pb;
            if (rst) begin
                st[i] = 0; nt[i] = 0; g[i] = 0; erev[i] = 0;
            end else begin
                tk = !ps && (g[i] % div_of(i) == div_of(i) - 1);
                if (!ps) g[i]++;
                erev[i] = 0;
                if (!st[i]) begin
                    if (gs) begin st[i] = 1; nt[i] = 0; end
                end else if (ll) begin
                    nt[i] = 0;
                end else if (tk) begin
                    pb = phase_of(nt[i]);
                    nt[i]++;
                    erev[i] = (pb >= 0) && (phase_of(nt[i]) != pb);
                end
            end
        end
        #1;
        game_start = 0; life_lost = 0; energizer_eaten = 0;
    endtask

    task automatic run_to_phase(input int p, output bit ok);
        ok = 0;
        for (int k = 0; k < 400; k++) begin
            if (ph[0] == p[2:0] && (sc[0] || ch[0])) begin ok = 1; break; end
            step(0, 0, 0, 0, 0);
        end
    endtask

    task automatic test_reset;
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (obs(i) !== 7'd0) begin
                n_err++; $display("FAIL reset_state dut%0d got=%b want=0", i, obs(i));
            end
        end
        for (int c = 0; c < 50; c++) begin
            step(0, 0, 0, c == 10, c == 20);
            for (int i = 0; i < 2; i++) begin
                n_cmp++;
                if (obs(i) !== 7'd0) begin
                    n_err++; $display("FAIL idle_hold dut%0d cyc=%0d got=%b want=0", i, c, obs(i));
                end
            end
        end
    endtask

    task automatic test_schedule;
        int cnt [8];
        int first_sc, rev_cnt, bad;
        logic [2:0] prev_ph;
        bit run, prev_run, exp_r;
        for (int p = 0; p < 8; p++) cnt[p] = 0;
        first_sc = -1; rev_cnt = 0; bad = 0; prev_ph = 0; prev_run = 0;
        step(1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        for (int i = 1; i <= 120; i++) begin
            step(0, 0, 0, 0, 0);
            run = sc[0] | ch[0];
            if (sc[0] && first_sc < 0) first_sc = i;
            if (run) cnt[ph[0]]++;
            if (sc[0] && ch[0]) bad++;
            if (run && (sc[0] !== ~ph[0][0])) bad++;
            exp_r = run && prev_run && (ph[0] != prev_ph);
            if (rv[0] !== exp_r) bad++;
            if (rv[0]) rev_cnt++;
            prev_ph = ph[0]; prev_run = run;
        end
        n_cmp++;
        if (first_sc != SD) begin n_err++; $display("FAIL start_delay got=%0d want=%0d", first_sc, SD); end
        for (int p = 0; p < 7; p++) begin
            n_cmp++;
            if (cnt[p] != dur(p)) begin
                n_err++; $display("FAIL phase_len p=%0d got=%0d want=%0d", p, cnt[p], dur(p));
            end
        end
        n_cmp++;
        if (cnt[7] != 120 - SD - 83) begin n_err++; $display("FAIL phase7_forever got=%0d want=%0d", cnt[7], 120 - SD - 83); end
        n_cmp++;
        if (rev_cnt != 7) begin n_err++; $display("FAIL reverse_count got=%0d want=7", rev_cnt); end
        n_cmp++;
        if (bad != 0) begin n_err++; $display("FAIL sched_consistency got=%0d bad cycles want=0", bad); end
    endtask

    task automatic test_pause;
        bit ok;
        int cnt;
        step(1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        run_to_phase(1, ok);
        n_cmp++;
        if (!ok) begin n_err++; $display("FAIL pause_reach got=timeout want=phase1"); end
        cnt = 1;
        for (int i = 0; i < 5; i++) begin step(0, 0, 0, 0, 0); if (ph[0] == 3'd1) cnt++; end
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 1, 0, 0);
            n_cmp++;
            if ({ch[0], sc[0], rv[0], ph[0]} !== 6'b100_001) begin
                n_err++; $display("FAIL pause_freeze cyc=%0d got=%b want=100001", i, {ch[0], sc[0], rv[0], ph[0]});
            end
            if (ph[0] == 3'd1) cnt++;
        end
        for (int i = 0; i < 100 && ph[0] == 3'd1; i++) begin
            step(0, 0, 0, 0, 0);
            if (ph[0] == 3'd1) cnt++;
        end
        n_cmp++;
        if (cnt != 30) begin n_err++; $display("FAIL pause_phase1_len got=%0d want=30", cnt); end
        n_cmp++;
        if ({rv[0], ph[0]} !== 4'b1_010) begin n_err++; $display("FAIL pause_exit got=%b want=1010", {rv[0], ph[0]}); end
    endtask

    task automatic test_life_lost;
        bit ok;
        step(1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        run_to_phase(3, ok);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        n_cmp++;
        if (obs(0) !== 7'd0 || !ok) begin n_err++; $display("FAIL life_lost_now got=%b ok=%0d want=0", obs(0), ok); end
        for (int i = 1; i <= 3; i++) begin
            step(0, 0, 0, 0, 0);
            n_cmp++;
            if (obs(0) !== ((i == 3) ? 7'b010_0000 : 7'd0)) begin
                n_err++; $display("FAIL life_lost_restart cyc=%0d got=%b", i, obs(0));
            end
        end
    endtask

    task automatic test_ll_energizer;
        bit ok;
        step(1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        run_to_phase(0, ok);
`ifdef FRIGHTENED_EN
        step(0, 0, 0, 0, 1);
        n_cmp++;
        if (fr[0] !== 1'b1) begin n_err++; $display("FAIL ll_eat_pre got=%b want=1", fr[0]); end
`endif
        step(0, 0, 0, 1, 1);
        n_cmp++;
        if (obs(0) !== 7'd0 || !ok) begin n_err++; $display("FAIL ll_eat_same got=%b ok=%0d want=0", obs(0), ok); end
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
        n_cmp++;
        if (obs(0) !== 7'b010_0000) begin n_err++; $display("FAIL ll_eat_restart got=%b want=0100000", obs(0)); end
    endtask

`ifdef FRIGHTENED_EN
    task automatic test_fright;
        bit ok;
        int fcnt, ccnt, bad;
        step(1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        run_to_phase(1, ok);
        for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        n_cmp++;
        if ({ch[0], sc[0], fr[0], rv[0], ph[0]} !== 7'b001_1001 || !ok) begin
            n_err++; $display("FAIL fright_entry got=%b want=0011001", obs(0));
        end
        fcnt = 1; bad = 0;
        for (int i = 0; i < 50 && fr[0]; i++) begin
            step(0, 0, 0, 0, 0);
            if (fr[0]) begin fcnt++; if (rv[0] || ch[0] || sc[0]) bad++; end
        end
        n_cmp++;
        if (fcnt != 6 || bad != 0) begin n_err++; $display("FAIL fright_len got=%0d bad=%0d want=6", fcnt, bad); end
        n_cmp++;
        if (obs(0) !== 7'b100_0001) begin n_err++; $display("FAIL fright_restore got=%b want=1000001", obs(0)); end
        ccnt = 1;
        for (int i = 0; i < 50 && ph[0] == 3'd1; i++) begin
            step(0, 0, 0, 0, 0);
            if (ph[0] == 3'd1 && ch[0]) ccnt++;
        end
        n_cmp++;
        if (ccnt != 10 || rv[0] !== 1'b1) begin n_err++; $display("FAIL fright_resume got=%0d rev=%b want=10", ccnt, rv[0]); end
        // re-eat during the third frightened cycle
        step(1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        run_to_phase(1, ok);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        n_cmp++;
        if (fr[0] !== 1'b1 || rv[0] !== 1'b0) begin n_err++; $display("FAIL reeat_no_rev got=%b%b want=10", fr[0], rv[0]); end
        fcnt = 4;
        for (int i = 0; i < 50 && fr[0]; i++) begin
            step(0, 0, 0, 0, 0);
            if (fr[0]) fcnt++;
        end
        n_cmp++;
        if (fcnt != 9) begin n_err++; $display("FAIL reeat_len got=%0d want=9", fcnt); end
    endtask
`endif

    task automatic test_random;
        int pause_left, shown;
        bit gs, ps, ll, ee;
        pause_left = 0; shown = 0;
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        for (int c = 0; c < 1500; c++) begin
            gs = ($urandom % 16 == 0);
            if (pause_left == 0 && $urandom % 20 == 0) pause_left = $urandom_range(1, 12);
            ps = (pause_left > 0);
            if (pause_left > 0) pause_left--;
            ll = ($urandom % 300 == 0);
`ifdef FRIGHTENED_EN
            ee = 0;
`else
            ee = ($urandom % 10 == 0);
`endif
            step(0, gs, ps, ll, ee);
            for (int i = 0; i < 2; i++) begin
                n_cmp++;
                if (obs(i) !== exp_vec(i)) begin
                    n_err++;
                    if (shown < 10) begin
                        shown++;
                        $display("FAIL random dut%0d cyc=%0d got=%b want=%b", i, c, obs(i), exp_vec(i));
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_schedule();
        test_pause();
        test_life_lost();
        test_ll_energizer();
`ifdef FRIGHTENED_EN
        test_fright();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
